memory_stall_controller: RTL and testbench

- Sequences the MEM stage. Generates the pipeline-advance enable `hit` that gates the EX/MEM register and every other pipeline register.
- On a data-cache read miss, freezes the pipeline and refills one cache block word-by-word from main memory over a request/ready handshake.
- On a store, performs a write-through to memory and stalls until memory accepts the write.
- Sits between the MEM-stage control bits, the data-cache tag compare and the main-memory port.

---
 rtl/memory_stall_controller_pkg.sv | 14 +
 rtl/stall_event_counter.sv | 29 ++
 rtl/memory_stall_controller.sv | 138 +++++++++++++
 tb/tb_memory_stall_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stall_controller_pkg.sv
// rtl/memory_stall_controller_pkg.sv - shared state encoding and block-geometry defaults
package memory_stall_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REFILL   = 2'd1,
        ST_VALIDATE = 2'd2,
        ST_WRITE    = 2'd3
    } state_t;

    localparam int DEFAULT_BLOCK_WORDS   = 4;
    localparam int DEFAULT_WORD_OFFSET_W = $clog2(DEFAULT_BLOCK_WORDS);

endpackage

// File: rtl/stall_event_counter.sv
// rtl/stall_event_counter.sv - saturating 32-bit event counter
module stall_event_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/memory_stall_controller.sv
// rtl/memory_stall_controller.sv - MEM-stage stall sequencer: block refill on read miss, write-through on store (optional STALL_COUNTERS_EN)
module memory_stall_controller
    import memory_stall_controller_pkg::*;
#(
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           mem_read,
    input  logic                           mem_write,
    input  logic [ADDR_WIDTH-1:0]          access_address,
    input  logic                           cache_hit,
    input  logic                           mem_ready,
    output logic                           hit,
    output logic                           mem_request,
    output logic                           mem_write_enable,
    output logic [ADDR_WIDTH-1:0]          mem_address,
    output logic                           fill_enable,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_index,
    output logic                           fill_valid_set
`ifdef STALL_COUNTERS_EN
    ,
    output logic [31:0]                    read_miss_count,
    output logic [31:0]                    write_stall_count,
    output logic [31:0]                    stall_cycle_count
`endif
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(BLOCK_WORDS - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        count_q, count_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

    // Byte offset within a word never reaches memory; all transfers are word-aligned.
    logic addr_byte_unused;
    assign addr_byte_unused = ^access_address[1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        addr_d           = addr_q;
        hit              = 1'b0;
        mem_request      = 1'b0;
        mem_write_enable = 1'b0;
        fill_enable      = 1'b0;
        fill_valid_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hit = !(mem_read && !cache_hit) && !mem_write;
                if (mem_write) begin
                    state_d = ST_WRITE;
                    addr_d  = {access_address[ADDR_WIDTH-1:2], 2'b00};
                end else if (mem_read && !cache_hit) begin
                    state_d = ST_REFILL;
                    count_d = '0;
                    addr_d  = {access_address[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                end
            end
            ST_REFILL: begin
                mem_request = 1'b1;
                fill_enable = mem_ready;
                if (mem_ready) begin
                    addr_d = addr_q + ADDR_WIDTH'(4);
                    if (count_q == LAST_WORD) begin
                        count_d = '0;
                        state_d = ST_VALIDATE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_VALIDATE: begin
                fill_valid_set = 1'b1;
                state_d        = ST_IDLE;
            end
            ST_WRITE: begin
                // Store retires in the accept cycle, so no bubble follows the write.
                mem_request      = 1'b1;
                mem_write_enable = 1'b1;
                hit              = mem_ready;
                if (mem_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_address     = addr_q;
    assign fill_word_index = count_q;

`ifdef STALL_COUNTERS_EN
    logic miss_evt, write_evt, stall_evt;

    assign miss_evt  = (state_q == ST_IDLE) && (state_d == ST_REFILL);
    assign write_evt = (state_q == ST_IDLE) && (state_d == ST_WRITE);
    // Only cycles spent waiting on the controller count; the request cycle itself does not.
    assign stall_evt = (state_q != ST_IDLE) && !hit;

    stall_event_counter u_read_miss_count (
        .clock (clock),
        .reset (reset),
        .inc   (miss_evt),
        .count (read_miss_count)
    );

    stall_event_counter u_write_stall_count (
        .clock (clock),
        .reset (reset),
        .inc   (write_evt),
        .count (write_stall_count)
    );

    stall_event_counter u_stall_cycle_count (
        .clock (clock),
        .reset (reset),
        .inc   (stall_evt),
        .count (stall_cycle_count)
    );
`endif

endmodule

// File: tb/tb_memory_stall_controller.sv
// tb/tb_memory_stall_controller.sv - randomized self-checking bench for memory_stall_controller
module tb_memory_stall_controller;

    localparam int BW = 4;
    localparam int AW = 32;
    localparam int IW = $clog2(BW);

    logic          clock = 1'b0;
    logic          reset;
    logic          mem_read, mem_write, cache_hit, mem_ready;
    logic [AW-1:0] access_address;
    logic          hit, mem_request, mem_write_enable, fill_enable, fill_valid_set;
    logic [AW-1:0] mem_address;
    logic [IW-1:0] fill_word_index;
`ifdef STALL_COUNTERS_EN
    logic [31:0]   read_miss_count, write_stall_count, stall_cycle_count;
`endif

    memory_stall_controller #(.BLOCK_WORDS(BW), .ADDR_WIDTH(AW)) dut (
        .clock            (clock),
        .reset            (reset),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .access_address   (access_address),
        .cache_hit        (cache_hit),
        .mem_ready        (mem_ready),
        .hit              (hit),
        .mem_request      (mem_request),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .fill_enable      (fill_enable),
        .fill_word_index  (fill_word_index),
        .fill_valid_set   (fill_valid_set)
`ifdef STALL_COUNTERS_EN
        ,
        .read_miss_count   (read_miss_count),
        .write_stall_count (write_stall_count),
        .stall_cycle_count (stall_cycle_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic          check_en = 1'b0;
    logic          exp_hit, exp_req, exp_we, exp_fen, exp_fvs, exp_addr_chk;
    logic [31:0]   exp_addr;
    int            exp_idx;

    logic [31:0]   fill_addr_cap[$];
    int            fill_idx_cap[$];
    int            fvs_cap;
    logic [31:0]   store_addr_cap[$];

    int unsigned   m_miss, m_write, m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%h expected=0x%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            chk("hit", 32'(hit), 32'(exp_hit));
            chk("mem_request", 32'(mem_request), 32'(exp_req));
            chk("mem_write_enable", 32'(mem_write_enable), 32'(exp_we));
            chk("fill_enable", 32'(fill_enable), 32'(exp_fen));
            chk("fill_valid_set", 32'(fill_valid_set), 32'(exp_fvs));
            if (exp_addr_chk) chk("mem_address", mem_address, exp_addr);
            if (exp_idx >= 0) chk("fill_word_index", 32'(fill_word_index), 32'(exp_idx));
            if (fill_enable) begin
                fill_addr_cap.push_back(mem_address);
                fill_idx_cap.push_back(int'(fill_word_index));
            end
            if (fill_valid_set) fvs_cap++;
            if (mem_request && mem_write_enable && mem_ready) store_addr_cap.push_back(mem_address);
        end
    end

    // One clock of stimulus with the outputs the specification demands for it.
    task automatic step(input logic rd, input logic wr, input logic ch, input logic rdy,
                        input logic [31:0] a,
                        input logic e_hit, input logic e_req, input logic e_we,
                        input logic e_fen, input logic e_fvs,
                        input logic [31:0] e_addr, input logic e_addr_chk, input int e_idx);
        mem_read       = rd;
        mem_write      = wr;
        cache_hit      = ch;
        mem_ready      = rdy;
        access_address = a;
        exp_hit        = e_hit;
        exp_req        = e_req;
        exp_we         = e_we;
        exp_fen        = e_fen;
        exp_fvs        = e_fvs;
        exp_addr       = e_addr;
        exp_addr_chk   = e_addr_chk;
        exp_idx        = e_idx;
        check_en       = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_access(input logic rd, input logic ch);
        step(rd, 1'b0, ch, 1'($urandom), $urandom(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, -1);
    endtask

    // wait_mode < 0 picks random memory latency per word.
    task automatic read_miss(input logic [31:0] a, input int wait_mode);
        logic [31:0] base;
        int w;
        int total;
        base  = a - (a % (BW * 4));
        total = 0;
        step(1'b1, 1'b0, 1'b0, 1'($urandom), a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, -1);
        for (int i = 0; i < BW; i++) begin
            w = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
            total += w + 1;
            repeat (w) step(1'b1, 1'b0, 1'($urandom), 1'b0, a, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                            base + 32'(4 * i), 1'b1, i);
            step(1'b1, 1'b0, 1'($urandom), 1'b1, a, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                 base + 32'(4 * i), 1'b1, i);
        end
        step(1'b1, 1'b0, 1'($urandom), 1'($urandom), a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, -1);
        m_miss++;
        m_stall += total + 1;
        idle_access(1'b1, 1'b1);
    endtask

    task automatic store(input logic [31:0] a, input logic also_read, input int wait_mode);
        logic [31:0] wa;
        int w;
        wa = a - (a % 4);
        w  = (wait_mode < 0) ? int'($urandom_range(0, 4)) : wait_mode;
        step(also_read, 1'b1, 1'($urandom), 1'($urandom), a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, -1);
        repeat (w) step(also_read, 1'b1, 1'($urandom), 1'b0, a, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, wa, 1'b1, -1);
        step(also_read, 1'b1, 1'($urandom), 1'b1, a, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, wa, 1'b1, -1);
        m_write++;
        m_stall += w;
    endtask

    task automatic check_counters();
`ifdef STALL_COUNTERS_EN
        chk("read_miss_count", read_miss_count, m_miss);
        chk("write_stall_count", write_stall_count, m_write);
        chk("stall_cycle_count", stall_cycle_count, m_stall);
`endif
    endtask

    initial begin
        reset          = 1'b1;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        cache_hit      = 1'b0;
        mem_ready      = 1'b0;
        access_address = '0;
        m_miss = 0; m_write = 0; m_stall = 0; fvs_cap = 0;
        #1;
        chk("reset_hit", 32'(hit), 32'd1);
        chk("reset_mem_request", 32'(mem_request), 32'd0);
        chk("reset_mem_write_enable", 32'(mem_write_enable), 32'd0);
        chk("reset_fill_enable", 32'(fill_enable), 32'd0);
        chk("reset_fill_valid_set", 32'(fill_valid_set), 32'd0);
        chk("reset_mem_address", mem_address, 32'd0);
        chk("reset_fill_word_index", 32'(fill_word_index), 32'd0);
        check_counters();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        repeat (3) idle_access(1'b1, 1'b1);
        repeat (2) idle_access(1'b0, 1'($urandom));

`ifdef STALL_COUNTERS_EN
        read_miss(32'h0000_0040, 0);
        store(32'h0000_0080, 1'b0, 1);
        chk("lit_read_miss_count", read_miss_count, 32'd1);
        chk("lit_write_stall_count", write_stall_count, 32'd1);
        chk("lit_stall_cycle_count", stall_cycle_count, 32'd6);
`endif

        fill_addr_cap.delete();
        fill_idx_cap.delete();
        fvs_cap = 0;
        read_miss(32'h0000_1234, 1);
        chk("lit_fill_count", 32'(fill_addr_cap.size()), 32'd4);
        if (fill_addr_cap.size() == 4) begin
            chk("lit_fill_addr0", fill_addr_cap[0], 32'h0000_1230);
            chk("lit_fill_addr1", fill_addr_cap[1], 32'h0000_1234);
            chk("lit_fill_addr2", fill_addr_cap[2], 32'h0000_1238);
            chk("lit_fill_addr3", fill_addr_cap[3], 32'h0000_123C);
            chk("lit_fill_idx3", 32'(fill_idx_cap[3]), 32'd3);
        end
        chk("lit_fill_valid_pulses", 32'(fvs_cap), 32'd1);

        store_addr_cap.delete();
        store(32'h0000_2007, 1'b0, 3);
        chk("lit_store_count", 32'(store_addr_cap.size()), 32'd1);
        if (store_addr_cap.size() == 1) chk("lit_store_addr", store_addr_cap[0], 32'h0000_2004);
        idle_access(1'b0, 1'b0);

        fill_addr_cap.delete();
        store(32'h0000_3010, 1'b1, 2);
        chk("both_no_refill", 32'(fill_addr_cap.size()), 32'd0);
        check_counters();

        // Abandon a refill while waiting on its second word.
        fvs_cap = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, -1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_5000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_5000, 1'b1, 0);
        check_en  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_mem_request", 32'(mem_request), 32'd0);
        chk("midrst_fill_enable", 32'(fill_enable), 32'd0);
        chk("midrst_mem_address", mem_address, 32'd0);
        chk("midrst_fill_word_index", 32'(fill_word_index), 32'd0);
        chk("midrst_hit", 32'(hit), 32'd1);
        @(posedge clock);
        #1 reset = 1'b0;
        m_miss = 0; m_write = 0; m_stall = 0;
        check_counters();
        read_miss(32'h0000_5008, -1);
        chk("midrst_valid_only_after_clean_refill", 32'(fvs_cap), 32'd1);

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 4))
                0: idle_access(1'b1, 1'b1);
                1: idle_access(1'b0, 1'($urandom));
                2: read_miss($urandom(), -1);
                3: store($urandom(), 1'b0, -1);
                default: store($urandom(), 1'b1, -1);
            endcase
            if (t % 10 == 9) check_counters();
        end
        check_counters();

        check_en = 1'b0;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
